// File: rtl/divider_arb_pkg.sv
// divider_arb_pkg
//   Shared definitions for the divider arbiter slice: FSM state encoding,
//   default parameter values and the watchdog counter width helper.
package divider_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RESPOND = 3'd3,
        ST_ABORT   = 3'd4
    } state_t;

    localparam int unsigned DEF_N_REQ   = 4;
    localparam int unsigned DEF_W       = 4;
    localparam int unsigned DEF_TIMEOUT = 31;

    // Width needed to hold a watchdog count of 0..timeout.
    function automatic int unsigned wd_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/divider_arbiter_rr.sv
// rr_arbiter
//   Combinational round-robin pick: lowest requesting index at or above ptr,
//   wrapping past N-1 back to 0.
//   req   : request vector
//   ptr   : search start index
//   grant : one-hot winner (all zero when no request)
//   idx   : binary winner index
//   any   : at least one request present
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] pos;
    logic          hit;

    always_comb begin
        grant = '0;
        idx   = '0;
        pos   = '0;
        hit   = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = IW'((32'(ptr) + k) % N);
            if (!hit && req[pos]) begin
                hit        = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/divider_arbiter.sv
// divider_arbiter
//   Shares one iterative divider among N_REQ requesters. A round-robin pick
//   accepts one request, screens divide-by-zero, launches the divider, waits
//   for done under a watchdog and returns the result to the winner.
//   clk, rst                 : clock, asynchronous active-low reset
//   req_valid/dividend/divisor : per-requester request (packed slices of W)
//   req_ready                : one-hot accept pulse
//   rsp_valid                : one-hot response pulse with rsp_quotient,
//                              rsp_remainder, rsp_error, rsp_timeout
//   div_*                    : controls to / results from the divider
//   busy                     : high whenever not idle
module divider_arbiter
    import divider_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = DEF_N_REQ,
    parameter int unsigned W       = DEF_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_dividend,
    input  logic [N_REQ*W-1:0] req_divisor,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [W-1:0]       rsp_quotient,
    output logic [W-1:0]       rsp_remainder,
    output logic               rsp_error,
    output logic               rsp_timeout,
    output logic               div_go,
    output logic [W-1:0]       div_dividend,
    output logic [W-1:0]       div_divisor,
    output logic [W-1:0]       div_n,
    output logic               div_rst,
    input  logic               div_done,
    input  logic               div_error,
    input  logic [W-1:0]       div_quotient,
    input  logic [W-1:0]       div_remainder,
    output logic               busy
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned CW = wd_width(TIMEOUT);

    state_t           state, state_nxt;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    g_idx;
    logic [N_REQ-1:0] g_vec;
    logic [N_REQ-1:0] owner;
    logic             any_req;
    logic [W-1:0]     sel_dividend, sel_divisor;
    logic [CW-1:0]    wd_cnt;
    logic             wd_expired;
    logic             zero_div;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (g_vec),
        .idx   (g_idx),
        .any   (any_req)
    );

    assign sel_dividend = req_dividend[32'(g_idx) * W +: W];
    assign sel_divisor  = req_divisor[32'(g_idx) * W +: W];

    // WAIT cycle k sees wd_cnt == k, so the last permitted cycle is TIMEOUT-1.
    assign wd_expired = (wd_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (any_req) state_nxt = (sel_divisor == '0) ? ST_RESPOND : ST_LAUNCH;
            ST_LAUNCH:  state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (div_done)        state_nxt = ST_RESPOND;
                else if (wd_expired) state_nxt = ST_ABORT;
            end
            ST_ABORT:   state_nxt = ST_RESPOND;
            ST_RESPOND: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // rsp_valid is raised on the edge the result becomes known: entering
    // RESPOND for divider/abort results, leaving RESPOND for a divide-by-zero,
    // so the zero-divisor response never overlaps its own req_ready pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            owner         <= '0;
            zero_div      <= 1'b0;
            wd_cnt        <= '0;
            req_ready     <= '0;
            rsp_valid     <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_error     <= 1'b0;
            rsp_timeout   <= 1'b0;
            div_go        <= 1'b0;
            div_dividend  <= '0;
            div_divisor   <= '0;
            div_n         <= '0;
            div_rst       <= 1'b1;
            busy          <= 1'b0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != ST_IDLE);
            req_ready <= '0;
            rsp_valid <= '0;
            div_go    <= 1'b0;
            div_rst   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        req_ready    <= g_vec;
                        owner        <= g_vec;
                        div_dividend <= sel_dividend;
                        div_divisor  <= sel_divisor;
                        div_n        <= W'(W);
                        ptr          <= (g_idx == IW'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
                        zero_div     <= (sel_divisor == '0);
                        if (sel_divisor == '0) begin
                            rsp_quotient  <= '0;
                            rsp_remainder <= '0;
                            rsp_error     <= 1'b1;
                            rsp_timeout   <= 1'b0;
                        end
                    end
                end
                ST_LAUNCH: begin
                    div_go <= 1'b1;
                    wd_cnt <= '0;
                end
                ST_WAIT: begin
                    if (div_done) begin
                        rsp_quotient  <= div_quotient;
                        rsp_remainder <= div_remainder;
                        rsp_error     <= div_error;
                        rsp_timeout   <= 1'b0;
                        rsp_valid     <= owner;
                    end else if (wd_expired) begin
                        div_rst       <= 1'b1;
                        rsp_quotient  <= '0;
                        rsp_remainder <= '0;
                        rsp_error     <= 1'b1;
                        rsp_timeout   <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_ABORT:   rsp_valid <= owner;
                ST_RESPOND: if (zero_div) rsp_valid <= owner;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_arbiter.sv
// tb_divider_arbiter
//   Directed bench for divider_arbiter with a behavioural divider whose
//   latency and hang behaviour are set from the stimulus.
module tb_divider_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_dividend;
    logic [15:0] req_divisor;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_quotient;
    logic [3:0]  rsp_remainder;
    logic        rsp_error;
    logic        rsp_timeout;
    logic        div_go;
    logic [3:0]  div_dividend;
    logic [3:0]  div_divisor;
    logic [3:0]  div_n;
    logic        div_rst;
    logic        div_done;
    logic        div_error;
    logic [3:0]  div_quotient;
    logic [3:0]  div_remainder;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    divider_arbiter #(
        .N_REQ   (4),
        .W       (4),
        .TIMEOUT (31)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_error     (rsp_error),
        .rsp_timeout   (rsp_timeout),
        .div_go        (div_go),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_n         (div_n),
        .div_rst       (div_rst),
        .div_done      (div_done),
        .div_error     (div_error),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural divider: done is visible in WAIT cycle lat+1 after go.
    int unsigned lat;
    logic        hang;
    logic        m_busy;
    int unsigned m_cnt;
    logic [3:0]  m_a, m_b;

    always @(posedge clk) begin
        if (div_rst) begin
            m_busy        <= 1'b0;
            m_cnt         <= 0;
            m_a           <= '0;
            m_b           <= '0;
            div_done      <= 1'b0;
            div_error     <= 1'b0;
            div_quotient  <= '0;
            div_remainder <= '0;
        end else begin
            div_done <= 1'b0;
            if (div_go && !hang) begin
                m_busy <= 1'b1;
                m_cnt  <= lat - 1;
                m_a    <= div_dividend;
                m_b    <= div_divisor;
            end else if (m_busy) begin
                if (m_cnt == 0) begin
                    m_busy        <= 1'b0;
                    div_done      <= 1'b1;
                    div_error     <= (m_b == 0);
                    div_quotient  <= (m_b == 0) ? 4'hf : m_a / m_b;
                    div_remainder <= (m_b == 0) ? m_a : m_a % m_b;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    int go_cnt;
    always @(negedge clk) begin
        if (!rst)        go_cnt <= 0;
        else if (div_go) go_cnt <= go_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_ready(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (req_ready != '0) found = 1'b1;
        end
        check({tag, "_seen"}, 32'(found), 32'd1);
    endtask

    task automatic wait_rsp(input string tag, output logic done_before);
        logic found;
        logic prev;
        found       = 1'b0;
        done_before = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            prev = div_done;
            step();
            if (rsp_valid != '0) begin
                found       = 1'b1;
                done_before = prev;
            end
        end
        check({tag, "_seen"}, 32'(found), 32'd1);
    endtask

    function automatic void set_req(input int unsigned i, input logic [3:0] a, input logic [3:0] b);
        req_dividend[i*4 +: 4] = a;
        req_divisor[i*4 +: 4]  = b;
    endfunction

    initial begin
        #100000;
        $display("FAIL global_watchdog: got no finish, expected finish before 100000 ns");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_q [4];
        logic [3:0] exp_r [4];
        logic [3:0] exp_v;
        logic       pd;
        int         bad;
        int         g0;

        exp_q = '{4'd4, 4'd2, 4'd1, 4'd15};
        exp_r = '{4'd1, 4'd0, 4'd0, 4'd0};

        lat          = 3;
        hang         = 1'b0;
        rst          = 1'b1;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        #1 rst = 1'b0;

        // Reset values
        repeat (3) step();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_div_rst",   32'(div_rst),   32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_div_go",    32'(div_go),    32'd0);
        check("rst_div_n",     32'(div_n),     32'd0);
        rst = 1'b1;
        step();
        check("rel_div_rst", 32'(div_rst), 32'd0);

        // Single request 13 / 3 from requester 0
        set_req(0, 4'd13, 4'd3);
        req_valid = 4'b0001;
        wait_ready("t1_ready");
        check("t1_ready_vec", 32'(req_ready), 32'h1);
        check("t1_go_early",  32'(div_go),    32'd0);
        check("t1_busy",      32'(busy),      32'd1);
        req_valid = '0;
        step();
        check("t1_go",       32'(div_go),       32'd1);
        check("t1_dividend", 32'(div_dividend), 32'd13);
        check("t1_divisor",  32'(div_divisor),  32'd3);
        check("t1_div_n",    32'(div_n),        32'd4);
        step();
        check("t1_go_pulse", 32'(div_go), 32'd0);
        check("t1_operand_hold", 32'(div_dividend), 32'd13);
        wait_rsp("t1_rsp", pd);
        check("t1_rsp_vec",   32'(rsp_valid),     32'h1);
        check("t1_q",         32'(rsp_quotient),  32'd4);
        check("t1_r",         32'(rsp_remainder), 32'd1);
        check("t1_err",       32'(rsp_error),     32'd0);
        check("t1_tmo",       32'(rsp_timeout),   32'd0);
        check("t1_after_done", 32'(pd),           32'd1);
        step();
        check("t1_rsp_pulse", 32'(rsp_valid), 32'd0);

        // Divide-by-zero from requester 2
        set_req(2, 4'd5, 4'd0);
        req_valid = 4'b0100;
        g0 = go_cnt;
        wait_ready("dz_ready");
        check("dz_ready_vec", 32'(req_ready), 32'h4);
        check("dz_no_rsp_yet", 32'(rsp_valid), 32'd0);
        req_valid = '0;
        step();
        check("dz_rsp_vec",  32'(rsp_valid),     32'h4);
        check("dz_ready_off", 32'(req_ready),    32'd0);
        check("dz_err",      32'(rsp_error),     32'd1);
        check("dz_tmo",      32'(rsp_timeout),   32'd0);
        check("dz_q",        32'(rsp_quotient),  32'd0);
        check("dz_r",        32'(rsp_remainder), 32'd0);
        repeat (3) step();
        check("dz_no_go", 32'(go_cnt), 32'(g0));

        // Timeout: requester 3 with a hung divider
        hang = 1'b1;
        set_req(3, 4'd14, 4'd5);
        req_valid = 4'b1000;
        wait_ready("to_ready");
        check("to_ready_vec", 32'(req_ready), 32'h8);
        req_valid = '0;
        step();
        check("to_go", 32'(div_go), 32'd1);
        bad = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (div_rst || rsp_valid != '0) bad++;
        end
        check("to_quiet", 32'(bad), 32'd0);
        step();
        check("to_div_rst",    32'(div_rst),   32'd1);
        check("to_no_rsp_yet", 32'(rsp_valid), 32'd0);
        step();
        check("to_div_rst_pulse", 32'(div_rst),     32'd0);
        check("to_rsp_vec",       32'(rsp_valid),   32'h8);
        check("to_err",           32'(rsp_error),   32'd1);
        check("to_tmo",           32'(rsp_timeout), 32'd1);
        check("to_q",             32'(rsp_quotient), 32'd0);
        check("to_r",             32'(rsp_remainder), 32'd0);
        hang = 1'b0;

        // Contention from ptr 0; requester 0 reissues right after its accept
        set_req(0, 4'd9,  4'd2);
        set_req(1, 4'd8,  4'd4);
        set_req(2, 4'd7,  4'd7);
        set_req(3, 4'd15, 4'd1);
        req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            exp_v = 4'b0001 << k;
            wait_ready($sformatf("ct%0d_ready", k));
            check($sformatf("ct%0d_ready_vec", k), 32'(req_ready), 32'(exp_v));
            if (k == 0) set_req(0, 4'd6, 4'd4);
            else        req_valid[k] = 1'b0;
            wait_rsp($sformatf("ct%0d_rsp", k), pd);
            check($sformatf("ct%0d_rsp_vec", k), 32'(rsp_valid),     32'(exp_v));
            check($sformatf("ct%0d_q", k),       32'(rsp_quotient),  32'(exp_q[k]));
            check($sformatf("ct%0d_r", k),       32'(rsp_remainder), 32'(exp_r[k]));
            check($sformatf("ct%0d_err", k),     32'(rsp_error),     32'd0);
        end
        wait_ready("ct_reissue_ready");
        check("ct_reissue_vec", 32'(req_ready), 32'h1);
        req_valid = '0;
        wait_rsp("ct_reissue_rsp", pd);
        check("ct_reissue_rsp_vec", 32'(rsp_valid),     32'h1);
        check("ct_reissue_q",       32'(rsp_quotient),  32'd1);
        check("ct_reissue_r",       32'(rsp_remainder), 32'd2);

        // Done arriving in the last permitted WAIT cycle still wins
        lat = 29;
        set_req(1, 4'd11, 4'd2);
        req_valid = 4'b0010;
        wait_ready("dw_ready");
        check("dw_ready_vec", 32'(req_ready), 32'h2);
        req_valid = '0;
        step();
        bad = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (div_rst || rsp_valid != '0) bad++;
        end
        check("dw_quiet", 32'(bad), 32'd0);
        step();
        check("dw_rsp_vec", 32'(rsp_valid),     32'h2);
        check("dw_no_abort", 32'(div_rst),      32'd0);
        check("dw_tmo",     32'(rsp_timeout),   32'd0);
        check("dw_err",     32'(rsp_error),     32'd0);
        check("dw_q",       32'(rsp_quotient),  32'd5);
        check("dw_r",       32'(rsp_remainder), 32'd1);

        // Reset in WAIT, then the reissued request completes
        lat = 10;
        set_req(1, 4'd10, 4'd3);
        req_valid = 4'b0010;
        wait_ready("rw_ready");
        req_valid = '0;
        repeat (4) step();
        rst = 1'b0;
        #1;
        check("rw_rsp_valid", 32'(rsp_valid),    32'd0);
        check("rw_req_ready", 32'(req_ready),    32'd0);
        check("rw_div_rst",   32'(div_rst),      32'd1);
        check("rw_busy",      32'(busy),         32'd0);
        check("rw_div_go",    32'(div_go),       32'd0);
        check("rw_dividend",  32'(div_dividend), 32'd0);
        check("rw_rsp_q",     32'(rsp_quotient), 32'd0);
        bad = 0;
        repeat (2) begin
            step();
            if (rsp_valid != '0 || !div_rst) bad++;
        end
        check("rw_hold", 32'(bad), 32'd0);
        rst = 1'b1;
        req_valid = 4'b0010;
        wait_ready("rw2_ready");
        check("rw2_ready_vec", 32'(req_ready), 32'h2);
        req_valid = '0;
        wait_rsp("rw2_rsp", pd);
        check("rw2_rsp_vec", 32'(rsp_valid),     32'h2);
        check("rw2_q",       32'(rsp_quotient),  32'd3);
        check("rw2_r",       32'(rsp_remainder), 32'd1);
        check("rw2_err",     32'(rsp_error),     32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/divider_arbiter.md
# divider_arbiter

Shares the single iterative `divider` datapath between `N_REQ` independent requesters. A round-robin grant picks one pending request, launches the divider with a `go` pulse, waits for `done`, and returns quotient, remainder and status to the winner. Divide-by-zero is screened before launch, and a watchdog aborts hung operations. The block sits directly in front of `divider`; requesters never touch the divider ports.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `W`, 4: operand width; also driven on `div_n`.
- `TIMEOUT`, 31: maximum WAIT cycles before abort (≥ W+2).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `req_valid`  in  N_REQ  per-requester request, held until accepted.
- `req_dividend`  in  N_REQ*W  packed, slice i belongs to requester i.
- `req_divisor`  in  N_REQ*W  packed, same layout.
- `req_ready`  out  N_REQ  one-hot, one-cycle accept pulse.
- `rsp_valid`  out  N_REQ  one-hot, one-cycle response pulse.
- `rsp_quotient`  out  W  valid when any `rsp_valid` bit is set.
- `rsp_remainder`  out  W  valid with `rsp_valid`.
- `rsp_error`  out  1  divide-by-zero, divider error or timeout.
- `rsp_timeout`  out  1  timeout abort; implies `rsp_error`.
- `div_go`, `div_dividend` (W), `div_divisor` (W), `div_n` (W)  out: divider controls.
- `div_rst`  out  1  divider reset, active-high.
- `div_done`, `div_error` (1), `div_quotient`, `div_remainder` (W)  in: divider results.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESPOND, ABORT.
- IDLE:
  - If any `req_valid`, the round-robin pick selects the lowest index at or above `ptr`, wrapping.
  - Pulse `req_ready[g]` and latch the operands and `g`.
  - Set `ptr = g+1 mod N_REQ`.
  - Latched divisor 0 → RESPOND with error, quotient 0, remainder 0; the divider is not launched.
  - Otherwise → LAUNCH.
- LAUNCH: `div_go`=1 for exactly this cycle with latched operands; `div_n`=W. → WAIT.
- WAIT:
  - The watchdog counts from 0 each cycle.
  - `div_done`=1 → latch quotient, remainder and `div_error`, then → RESPOND.
  - Count reaches `TIMEOUT` with no `div_done` → ABORT.
- ABORT: `div_rst`=1 for one cycle; latch error=1, timeout=1, quotient=0, remainder=0. → RESPOND.
- RESPOND: `rsp_valid[g]`=1 for one cycle with latched data. → IDLE.
- Operands on `div_dividend`/`div_divisor` stay stable from LAUNCH through the end of WAIT.
- Requests arriving while busy wait. `req_valid` dropped before accept is legal; that request is simply not served.
- `div_done` seen outside WAIT is ignored.

## Timing
- Reset values:
  - All outputs 0 except `div_rst`=1.
  - `div_rst` releases on the first clock after `rst` deasserts.
  - State IDLE, `ptr`=0.
- Accept-to-launch: 1 cycle. Response appears 1 cycle after `div_done`. Minimum turnaround is IDLE→LAUNCH→WAIT(done)→RESPOND→IDLE, i.e. 4 cycles plus divider latency.
- Divide-by-zero: `rsp_valid` comes 1 cycle after `req_ready`.
- Outputs are registered. `req_ready` and `rsp_valid` are never both set for the same requester in the same cycle.
- `div_done` arriving in the same cycle the watchdog hits `TIMEOUT`: done wins, normal response.
- Reset mid-operation: immediate return to IDLE; the in-flight request gets no response, and the requester reissues it.

## Structure
- Package `divider_arb_pkg`: state enum, default `W`/`N_REQ`/`TIMEOUT` constants, watchdog counter width `$clog2(TIMEOUT+1)`.
- Sub-module `rr_arbiter`: combinational request vector + `ptr` → one-hot grant and index. The FSM and the `ptr` register stay in `divider_arbiter`.

## Test plan
- Single request: req0 with 13÷3 → `div_go` pulse 1 cycle after `req_ready[0]`; `rsp_valid[0]` with q=4, r=1, error=0.
- Contention: all four requesters valid with 9÷2, 8÷4, 7÷7, 15÷1 → served in order 0,1,2,3 with results (4,1), (2,0), (1,0), (15,0). Requester 0 reissuing immediately is served after 3.
- Divide-by-zero: req2 with 5÷0 → `rsp_valid[2]` one cycle after accept, error=1, q=r=0, `div_go` never asserted.
- Timeout: divider model never raises done → after 31 WAIT cycles, `div_rst` pulses once, then `rsp_valid` with error=1, timeout=1. The next request completes normally.
- Reset in WAIT: `rst` low mid-divide → all outputs at reset values, `div_rst`=1, no `rsp_valid`; after release the same request completes.
